// File: rtl/weight_fetch_fire5_if.sv
// Weight row handshake between the fetch sequencer and the expand3 MAC array.
// The master drives a registered row plus valid; the slave returns ready.
interface weight_fetch_fire5_if #(
  parameter int WIDTH = 16,
  parameter int NUM   = 128
);
  logic [WIDTH-1:0] w_out [0:NUM-1];
  logic             w_valid;
  logic             w_ready;

  modport master (
    output w_out,
    output w_valid,
    input  w_ready
  );

  modport slave (
    input  w_out,
    input  w_valid,
    output w_ready
  );
endinterface

// File: rtl/weight_fetch_fire5.sv
// Fire5 expand3 weight fetch: walks ROM rows 0..DEPTH-1 into a valid/ready bank.
// Define WFETCH_CHECKSUM_EN to build the running XOR checksum of loaded rows.
module weight_fetch_fire5 #(
  parameter int WIDTH = 16,
  parameter int NUM   = 128,
  parameter int ADDR  = 9,
  parameter int DEPTH = 288
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic [ADDR-1:0]     address,
  input  logic [WIDTH-1:0]    rom_in [0:NUM-1],
  weight_fetch_fire5_if.master wbus,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    checksum
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [ADDR:0]   LAST = (ADDR+1)'(DEPTH);
  localparam logic [ADDR-1:0] TOP  = ADDR'(DEPTH-1);

  state_t          state;
  state_t          state_n;
  logic [ADDR:0]   issued;
  logic            load;
  logic            fin;
  logic            go;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    fin     = 1'b0;
    go      = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      S_IDLE: begin
        go = start;
        if (start) state_n = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        load = (!wbus.w_valid || wbus.w_ready) && (issued < LAST);
        fin  = wbus.w_valid && wbus.w_ready && (issued == LAST);
        if (fin) state_n = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Address stops at the last row so it never wraps to 0 mid-pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      address      <= '0;
      issued       <= '0;
      wbus.w_valid <= 1'b0;
      for (int k = 0; k < NUM; k++) wbus.w_out[k] <= '0;
    end else begin
      if (go) issued <= '0;
      if (state == S_DONE) address <= '0;
      if (load) begin
        for (int k = 0; k < NUM; k++) wbus.w_out[k] <= rom_in[k];
        wbus.w_valid <= 1'b1;
        issued       <= issued + 1'b1;
        if (address != TOP) address <= address + 1'b1;
      end else if (fin) begin
        wbus.w_valid <= 1'b0;
      end
    end
  end

`ifdef WFETCH_CHECKSUM_EN
  logic [WIDTH-1:0] row_x;

  always_comb begin
    row_x = '0;
    for (int k = 0; k < NUM; k++) row_x = row_x ^ rom_in[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    checksum <= '0;
    else if (go)   checksum <= '0;
    else if (load) checksum <= checksum ^ row_x;
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_weight_fetch_fire5.sv
// Directed + randomized bench for weight_fetch_fire5 with an arithmetic ROM
// and a row-count / XOR reference model.
module tb_weight_fetch_fire5;
  localparam int WIDTH = 16;
  localparam int NUM   = 128;
  localparam int ADDR  = 9;
  localparam int DEPTH = 288;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [ADDR-1:0]  address;
  logic [WIDTH-1:0] rom [0:NUM-1];
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] checksum;
  int               rom_mode;
  int               n_cmp = 0;
  int               n_bad = 0;
  logic [15:0]      last_ck;

  weight_fetch_fire5_if #(.WIDTH(WIDTH), .NUM(NUM)) wbus ();

  weight_fetch_fire5 #(
    .WIDTH(WIDTH), .NUM(NUM), .ADDR(ADDR), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .address(address), .rom_in(rom), .wbus(wbus),
    .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input int m, input int r, input int k);
    if (m == 0) return 16'((r * NUM + k) % 65536);
    if (m == 2 && r == 5 && k == 0) return 16'h00FF;
    return 16'h0001;
  endfunction

  always_comb begin
    for (int k = 0; k < NUM; k++) rom[k] = 16'h0;
    for (int k = 0; k < NUM; k++) rom[k] = rom_word(rom_mode, int'(address), k);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // rmode: 0 ready high, 1 pattern 1,0,0,1, 2 random.
  task automatic run_pass(input int rmode, input int poke_row, input int rst_row,
                          output int acc);
    logic [15:0] ck;
    logic [15:0] hold_w0;
    logic [8:0]  hold_a;
    logic        stalled;
    logic        seen_done;
    logic        poked;
    logic        aborted;
    logic        took;
    int          ea;
    acc = 0; ck = 0; stalled = 0; seen_done = 0; poked = 0; aborted = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_no_valid", wbus.w_valid, 0);
    chk("start_cksum_clr", checksum, 0);
    for (int cyc = 0; cyc < 4000 && !seen_done; cyc++) begin
      if (acc == rst_row) begin
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", wbus.w_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_addr", address, 0);
        chk("arst_w0", wbus.w_out[0], 0);
        chk("arst_cksum", checksum, 0);
        aborted = 1;
        break;
      end
      start = (poke_row >= 0 && acc == poke_row && !poked);
      if (start) poked = 1;
      case (rmode)
        0:       wbus.w_ready = 1'b1;
        1:       wbus.w_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: wbus.w_ready = 1'($urandom_range(0, 1));
      endcase
      if (stalled) begin
        chk("stall_w0", wbus.w_out[0], 32'(hold_w0));
        chk("stall_addr", address, 32'(hold_a));
      end
      if (rmode == 0) chk("no_bubble", wbus.w_valid, cyc >= 1);
      ea = !wbus.w_valid ? 0 : (acc + 1 > DEPTH - 1 ? DEPTH - 1 : acc + 1);
      chk("address", address, 32'(ea));
      took = wbus.w_valid && wbus.w_ready;
      if (wbus.w_valid) begin
        chk("row_w0", wbus.w_out[0], 32'(rom_word(rom_mode, acc, 0)));
        chk("row_wlast", wbus.w_out[NUM-1], 32'(rom_word(rom_mode, acc, NUM-1)));
        stalled = !wbus.w_ready;
        hold_w0 = wbus.w_out[0];
        hold_a  = address;
        if (took) begin
          for (int k = 0; k < NUM; k++) ck = ck ^ rom_word(rom_mode, acc, k);
          acc++;
        end
      end else begin
        stalled = 0;
      end
      step();
      start = 1'b0;
      chk("done", done, took && acc == DEPTH);
      chk("busy", busy, !(took && acc == DEPTH));
      if (done) seen_done = 1;
    end
    if (aborted) begin
      step();
      chk("arst_no_done", done, 0);
      chk("arst_still_idle", wbus.w_valid, 0);
      rst_n = 1'b1;
      step();
      chk("arst_rel_busy", busy, 0);
    end else begin
      chk("pass_finished", seen_done, 1);
`ifdef WFETCH_CHECKSUM_EN
      chk("checksum", checksum, 32'(ck));
`else
      chk("checksum_off", checksum, 0);
`endif
      start = (poke_row >= 0);
      step();
      start = 1'b0;
      chk("done_once", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_addr", address, 0);
      step();
      chk("idle_stays", busy, 0);
      chk("idle_valid", wbus.w_valid, 0);
`ifdef WFETCH_CHECKSUM_EN
      chk("checksum_hold", checksum, 32'(ck));
`else
      chk("checksum_hold_off", checksum, 0);
`endif
    end
    last_ck = ck;
  endtask

  initial begin
    int acc;
    rst_n = 1'b0;
    start = 1'b0;
    wbus.w_ready = 1'b0;
    rom_mode = 0;
    #12;
    chk("rst_addr", address, 0);
    chk("rst_valid", wbus.w_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cksum", checksum, 0);
    chk("rst_w0", wbus.w_out[0], 0);
    rst_n = 1'b1;
    step();
    step();
    wbus.w_ready = 1'b1;
    step();
    chk("ready_idle_noeffect", wbus.w_valid, 0);

    run_pass(0, -1, -1, acc);
    chk("full_rows", acc, DEPTH);
    chk("last_row_w0", 32'(rom_word(0, DEPTH - 1, 0)), 32'd36736);
    run_pass(1, -1, -1, acc);
    chk("bp_rows", acc, DEPTH);
    run_pass(2, -1, -1, acc);
    chk("rand_rows", acc, DEPTH);
    run_pass(0, 100, -1, acc);
    chk("restart_ignored_rows", acc, DEPTH);
    run_pass(0, -1, 150, acc);
    chk("abort_rows", acc, 150);
    run_pass(2, -1, -1, acc);
    chk("after_abort_rows", acc, DEPTH);

    rom_mode = 1;
    run_pass(0, -1, -1, acc);
    chk("ones_cksum_model", 32'(last_ck), 0);
    rom_mode = 2;
    run_pass(2, -1, -1, acc);
    chk("patch_cksum_model", 32'(last_ck), 32'h00FE);
`ifdef WFETCH_CHECKSUM_EN
    chk("patch_cksum", checksum, 32'h00FE);
`else
    chk("patch_cksum_off", checksum, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
